// File: rtl/count_driver_pkg.sv
// Shared types for the count_driver block.
//   state_t : move-sequencer states (IDLE, RUN, GAP, FIN)
//   dir_t   : direction of the current move (DIR_UP, DIR_DOWN)
package count_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    FIN
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

endpackage

// File: rtl/count_driver_interval_timer.sv
// Spacing timer for the GAP state of count_driver.
// A load starts a countdown covering the INTERVAL-1 idle cycles that follow
// a pulse. expire is high in the last of those cycles, and whenever the timer
// is not running.
//   clk    : clock
//   rst    : asynchronous active-high reset
//   load   : high on the edge that leaves RUN for GAP
//   expire : countdown finished; the next edge may issue a pulse
module interval_timer #(
  parameter int INTERVAL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int CW = (INTERVAL > 2) ? $clog2(INTERVAL - 1) : 1;
  // The GAP state lasts INTERVAL-1 cycles and ends in the cycle where the
  // count reads zero, so the reload value is INTERVAL-2.
  localparam logic [CW-1:0] RELOAD = CW'(INTERVAL - 2);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/count_driver.sv
// Target-seeking pulse generator for a WIDTH-bit wrapping up/down counter.
// The block accepts a target value and then emits single-cycle up or down
// pulses along the shorter modular path until its shadow count equals the
// target.
//   clk          : clock, all state on the rising edge
//   rst          : asynchronous active-high reset
//   target_valid : new target offered
//   target       : requested counter value
//   target_ready : high in IDLE; accept on valid && ready
//   abort        : abandon the current move and return to IDLE
//   up / down    : registered one-cycle pulses to the driven counter
//   count        : shadow of the driven counter's value
//   busy         : move in progress
//   done         : one-cycle pulse when a move completes
module count_driver
  import count_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int INTERVAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             target_valid,
  input  logic [WIDTH-1:0] target,
  output logic             target_ready,
  input  logic             abort,
  output logic             up,
  output logic             down,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_q,  state_d;
  dir_t             dir_q,    dir_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             up_q,     up_d;
  logic             down_q,   down_d;
  logic             done_q,   done_d;

  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] step;
  logic             expire;

  // Distance from the shadow count to an offered target, modulo 2^WIDTH.
  assign diff = target - count_q;
  // Shadow value after the pulse currently on the up/down outputs lands.
  assign step = (dir_q == DIR_UP) ? count_q + ONE : count_q - ONE;

  generate
    if (INTERVAL > 1) begin : g_gap
      logic gap_load;
      assign gap_load = (state_q == RUN) && (state_d == GAP);

      interval_timer #(
        .INTERVAL(INTERVAL)
      ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (gap_load),
        .expire(expire)
      );
    end else begin : g_no_gap
      // GAP is unreachable when pulses come every cycle.
      assign expire = 1'b1;
    end
  endgenerate

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    dir_d    = dir_q;
    count_d  = count_q;
    target_d = target_q;
    up_d     = 1'b0;
    down_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort has no effect here; an accept still proceeds.
        if (target_valid) begin
          target_d = target;
          if (diff == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            // A tie at exactly half range resolves to up.
            dir_d   = (diff <= HALF) ? DIR_UP : DIR_DOWN;
            state_d = RUN;
            up_d    = (dir_d == DIR_UP);
            down_d  = (dir_d == DIR_DOWN);
          end
        end
      end

      RUN: begin
        // The pulse is already on the wire and the driven counter takes it
        // on this edge, so the shadow follows it even when aborting.
        count_d = step;
        if (abort) begin
          state_d = IDLE;
        end else if (step == target_q) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else if (INTERVAL > 1) begin
          state_d = GAP;
        end else begin
          up_d   = (dir_q == DIR_UP);
          down_d = (dir_q == DIR_DOWN);
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (expire) begin
          state_d = RUN;
          up_d    = (dir_q == DIR_UP);
          down_d  = (dir_q == DIR_DOWN);
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dir_q    <= DIR_UP;
      count_q  <= '0;
      target_q <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      count_q  <= count_d;
      target_q <= target_d;
      up_q     <= up_d;
      down_q   <= down_d;
      done_q   <= done_d;
    end
  end

  assign up           = up_q;
  assign down         = down_q;
  assign done         = done_q;
  assign count        = count_q;
  assign target_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_count_driver.sv
// Self-checking bench for count_driver. Two instances share clock and reset:
// dut0 with INTERVAL=1 and dut1 with INTERVAL=4. Each move's expected pulse
// schedule is derived from the start value, the target and the interval.
module tb_count_driver;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]   tv;
  logic [1:0]   abort;
  logic [W-1:0] tg     [2];
  logic         ready0, ready1, up0, up1, down0, down1;
  logic         busy0, busy1, done0, done1;
  logic [W-1:0] count0, count1;

  logic [1:0]   ready, up, down, busy, done;
  logic [W-1:0] count [2];

  assign ready    = {ready1, ready0};
  assign up       = {up1, up0};
  assign down     = {down1, down0};
  assign busy     = {busy1, busy0};
  assign done     = {done1, done0};
  assign count[0] = count0;
  assign count[1] = count1;

  count_driver #(.WIDTH(W), .INTERVAL(1)) dut0 (
    .clk(clk), .rst(rst), .target_valid(tv[0]), .target(tg[0]),
    .target_ready(ready0), .abort(abort[0]), .up(up0), .down(down0),
    .count(count0), .busy(busy0), .done(done0)
  );

  count_driver #(.WIDTH(W), .INTERVAL(4)) dut1 (
    .clk(clk), .rst(rst), .target_valid(tv[1]), .target(tg[1]),
    .target_ready(ready1), .abort(abort[1]), .up(up1), .down(down1),
    .count(count1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int track_err = 0;

  logic [W-1:0] mcount  [2];
  logic [W-1:0] ref_cnt [2];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  // Reference up/down counter fed by the pulses, as the driven counter would be.
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) ref_cnt[d] <= '0;
      else if (up[d]) ref_cnt[d] <= ref_cnt[d] + 16'd1;
      else if (down[d]) ref_cnt[d] <= ref_cnt[d] - 16'd1;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (count[d] !== ref_cnt[d] || (up[d] && down[d]) || ((up[d] || down[d]) && !busy[d])) begin
        if (track_err < 5)
          $display("tracking error dut%0d t=%0t count=%0d ref=%0d up=%b down=%b busy=%b",
                   d, $time, count[d], ref_cnt[d], up[d], down[d], busy[d]);
        track_err++;
      end
    end
  end

  // Shortest modular path from 'from' to 'to'.
  function automatic void plan(input logic [W-1:0] from, input logic [W-1:0] to, input int iv,
                               output int n, output bit dir_up, output int lat);
    int diff;
    diff = ((int'(to) - int'(from)) % 65536 + 65536) % 65536;
    dir_up = 1'b1;
    if (diff == 0) n = 0;
    else if (diff <= 32768) n = diff;
    else begin
      n = 65536 - diff;
      dir_up = 1'b0;
    end
    lat = (n == 0) ? 1 : (n - 1) * iv + 2;
  endfunction

  // Offer target t to dut d and follow the whole move cycle by cycle.
  task automatic move(input string name, input int d, input logic [W-1:0] t, input int iv,
                      input int n, input bit dir_up, input int lat, input bit poke, input bit ab);
    int bad = 0;
    bit pulse, exp_up, exp_dn, exp_done;
    @(negedge clk);
    check({name, " ready"}, ready[d], 1);
    tv[d] = 1'b1;
    tg[d] = t;
    abort[d] = ab;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      pulse = (n > 0) && ((k - 1) % iv == 0) && ((k - 1) / iv < n);
      exp_up = pulse && dir_up;
      exp_dn = pulse && !dir_up;
      exp_done = (k == lat);
      if (up[d] !== exp_up || down[d] !== exp_dn || done[d] !== exp_done) begin
        if (bad == 0)
          $display("  %s: first deviation at cycle %0d: up=%b down=%b done=%b (want %b %b %b)",
                   name, k, up[d], down[d], done[d], exp_up, exp_dn, exp_done);
        bad++;
      end
      if (k == 1) begin
        tv[d] = 1'b0;
        abort[d] = 1'b0;
      end
      if (poke && k == 2) begin
        tv[d] = 1'b1;
        tg[d] = t + 16'd1000;
      end
      if (poke && k == 3) tv[d] = 1'b0;
    end
    check({name, " pulse deviations"}, bad, 0);
    check({name, " final count"}, count[d], t);
    mcount[d] = t;
  endtask

  // Start a move, abort it at cycle abort_k, then confirm it stays quiet.
  task automatic abort_move(input string name, input int d, input int abort_k, input int exp_steps);
    logic [W-1:0] c;
    int stray = 0;
    c = mcount[d];
    @(negedge clk);
    tv[d] = 1'b1;
    tg[d] = c + 16'd10;
    for (int k = 1; k <= abort_k; k++) begin
      @(negedge clk);
      tv[d] = 1'b0;
    end
    abort[d] = 1'b1;
    @(negedge clk);
    abort[d] = 1'b0;
    check({name, " busy after abort"}, busy[d], 0);
    check({name, " count after abort"}, count[d], c + W'(exp_steps));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (up[d] || down[d] || done[d]) stray++;
    end
    check({name, " stray activity"}, stray, 0);
    mcount[d] = c + W'(exp_steps);
  endtask

  typedef struct {
    int d;
    logic [W-1:0] t;
    int n;
    bit dir_up;
    int lat;
    bit poke;
    bit ab;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n, lat, iv, d;
    bit dir_up;
    logic [W-1:0] t, c;

    rst = 1'b1;
    tv = '0;
    abort = '0;
    tg[0] = '0;
    tg[1] = '0;
    mcount[0] = '0;
    mcount[1] = '0;

    // Hand-derived moves: {dut, target, pulses, up?, latency, poke, abort-at-accept}
    vecs.push_back('{0, 16'd5,     5,     1'b1, 6,     1'b0, 1'b0});
    vecs.push_back('{0, 16'd3,     2,     1'b0, 3,     1'b1, 1'b0});
    vecs.push_back('{0, 16'd65534, 5,     1'b0, 6,     1'b0, 1'b0});
    vecs.push_back('{0, 16'd7,     9,     1'b1, 10,    1'b0, 1'b0});
    vecs.push_back('{0, 16'd7,     0,     1'b1, 1,     1'b0, 1'b0});
    vecs.push_back('{0, 16'd0,     7,     1'b0, 8,     1'b0, 1'b1});
    vecs.push_back('{0, 16'd32768, 32768, 1'b1, 32769, 1'b0, 1'b0});
    vecs.push_back('{1, 16'd3,     3,     1'b1, 10,    1'b1, 1'b0});
    vecs.push_back('{1, 16'd65535, 4,     1'b0, 14,    1'b0, 1'b0});
    vecs.push_back('{1, 16'd65535, 0,     1'b1, 1,     1'b0, 1'b0});
    vecs.push_back('{1, 16'd1,     2,     1'b1, 6,     1'b0, 1'b0});

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset dut%0d count", i), count[i], 0);
      check($sformatf("reset dut%0d up/down/done", i), {up[i], down[i], done[i]}, 0);
      check($sformatf("reset dut%0d busy", i), busy[i], 0);
      check($sformatf("reset dut%0d ready", i), ready[i], 1);
    end
    rst = 1'b0;

    foreach (vecs[i]) begin
      iv = (vecs[i].d == 1) ? 4 : 1;
      move($sformatf("vec%0d", i), vecs[i].d, vecs[i].t, iv, vecs[i].n, vecs[i].dir_up,
           vecs[i].lat, vecs[i].poke, vecs[i].ab);
    end

    // Random short moves checked against the path model.
    for (int i = 0; i < 30; i++) begin
      d = i % 2;
      iv = (d == 1) ? 4 : 1;
      if ($urandom_range(0, 3) == 0) t = mcount[d];
      else t = mcount[d] + W'($urandom_range(0, 60)) - 16'd30;
      plan(mcount[d], t, iv, n, dir_up, lat);
      move($sformatf("rand%0d", i), d, t, iv, n, dir_up, lat, 1'b0, 1'($urandom_range(0, 1)));
    end

    // Abort concurrent with the 2nd of 10 pulses, and abort inside a GAP.
    abort_move("abort run", 0, 2, 2);
    abort_move("abort gap", 1, 2, 1);

    // Reset in the middle of a move.
    c = mcount[0];
    @(negedge clk);
    tv[0] = 1'b1;
    tg[0] = c + 16'd100;
    repeat (3) @(negedge clk);
    tv[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset count", count[0], 0);
    check("midreset outputs", {up[0], down[0], done[0], busy[0]}, 0);
    check("midreset ready", ready[0], 1);
    check("midreset dut1 count", count[1], 0);
    @(negedge clk);
    rst = 1'b0;
    mcount[0] = '0;
    mcount[1] = '0;

    plan(mcount[0], 16'd2, 1, n, dir_up, lat);
    move("post reset dut0", 0, 16'd2, 1, n, dir_up, lat, 1'b0, 1'b0);
    plan(mcount[1], 16'd65534, 4, n, dir_up, lat);
    move("post reset dut1", 1, 16'd65534, 4, n, dir_up, lat, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("tracking errors", track_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/count_driver.md
Name: count_driver

Overview:
Target-seeking pulse generator that drives the up/down control inputs of a WIDTH-bit wrapping up/down counter. It accepts a target value over a valid/ready handshake. It then emits single-cycle up or down pulses, taking the shortest modular path, until its shadow copy of the counter equals the target. It is the producing end of the up/down counter control interface, used as a stimulus source and as a position controller.

Parameters:
WIDTH, 16, bit width of target, shadow count and the driven counter
INTERVAL, 1, clock cycles from one pulse to the next (>=1); 1 = a pulse every cycle

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
target_valid  in  1  new target offered
target  in  WIDTH  requested counter value
target_ready  out  1  high when in IDLE; a target is accepted on a clk edge with valid&&ready
abort  in  1  stop the current move; return to IDLE
up  out  1  increment pulse to the driven counter
down  out  1  decrement pulse to the driven counter
count  out  WIDTH  shadow count, equals the driven counter's value
busy  out  1  move in progress
done  out  1  one-cycle pulse when a move completes (not on abort)

Behaviour:
- Reset (async): state=IDLE; count=0; up=down=done=busy=0; target_ready=1; interval counter=0. Matches a counter reset to 0 by the same rst.
- All outputs are registered. target_ready=(state==IDLE). busy=(state!=IDLE).
- States:
  - IDLE:
    - On accept, latch target and compute diff=(target-count) mod 2^WIDTH.
    - diff==0: go to FIN.
    - diff<=2^(WIDTH-1): direction=up, go to RUN. A tie at exactly half range resolves to up.
    - Otherwise: direction=down, go to RUN.
  - RUN:
    - Assert exactly one of up/down for one cycle.
    - count updates on the same edge the driven counter samples the pulse, so count tracks the driven counter with zero lag.
    - count wraps modulo 2^WIDTH: 2^WIDTH-1 +1 -> 0, and 0 -1 -> 2^WIDTH-1.
    - If the pulse makes count==target, go to FIN.
    - Else if INTERVAL>1, go to GAP.
    - Else stay in RUN.
  - GAP: up=down=0 for INTERVAL-1 cycles, then go to RUN.
  - FIN: done=1 for one cycle, then go to IDLE.
- Move timing: a move of N steps (N=min(diff, 2^WIDTH-diff)) produces exactly N pulses.
  - First pulse is visible the cycle after accept.
  - done is asserted the cycle after the last pulse.
  - Total accept-to-done latency = (N-1)*INTERVAL + 2 cycles. For diff==0 it is 1 cycle.
- up and down are never high in the same cycle. They are never high outside RUN.
- target_valid outside IDLE is ignored; there is no queuing. target is sampled only at accept.
- abort:
  - Honoured in RUN/GAP/FIN: go to IDLE next edge, with no further pulses and no done.
  - count keeps the value of every pulse already issued.
  - If abort and a pulse would coincide, abort wins and no pulse is issued that cycle.
  - abort in IDLE has no effect; an accept in the same cycle still proceeds.
- rst mid-move: immediately clears to the reset state above. The driven counter, sharing rst, also returns to 0, so tracking is preserved.

Decomposition:
- Package count_pkg: state_t enum (IDLE, RUN, GAP, FIN); dir_t enum (DIR_UP, DIR_DOWN).
- Natural sub-module interval_timer (INTERVAL param; load/expire) for GAP spacing. count_driver instantiates it only when INTERVAL>1.
- The arithmetic stays inline.

Test Plan:
- Reset, then target=5 (WIDTH=16, INTERVAL=1) -> 5 consecutive up pulses starting 1 cycle after accept; count 1..5; done the cycle after; no down pulses.
- From count=3, target=65534 -> diff=65531 > 32768, so 5 down pulses wrapping 3,2,1,0,65535,65534; done asserted.
- Tie: from count=0, target=32768 -> up chosen, 32768 up pulses, done.
- Target equal to current count=7 -> zero pulses; done 1 cycle after accept; target_ready back high next cycle.
- INTERVAL=4, from 0 to target=3 -> up pulses at cycles 1, 5, 9 after accept; done at cycle 10. target_valid pulsed during the move is ignored.
- Abort and reset: abort after 2 of 10 up pulses -> IDLE, count=2, no done. Then rst asserted mid-move -> all outputs 0 asynchronously, count=0. Throughout, compare against a reference up/down counter driven by up/down: count equals its value every cycle, and up&&down is never high.
